mux_32x8: RTL and testbench
===========================

MUX_32X8 -- requirements
Module: mux_32x8

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk_4f and reset_L.
REQ-002 The port clk_4f SHALL be an input, 1 bit wide, and serve as the byte-rate clock; all state SHALL update on its rising edge.
REQ-003 The port reset_L SHALL be an input, 1 bit wide, asynchronous and active-low, and clear all state.
REQ-004 The port data_in_32x8 SHALL be an input, 32 bits wide, carrying the parallel word to serialize.
REQ-005 The port valid_in_32x8 SHALL be an input, 1 bit wide, and mark data_in_32x8 as valid.
REQ-006 The port ready_out_32x8 SHALL be an output, 1 bit wide, and indicate that a word will be accepted on this edge.
REQ-007 The port data_out_32x8 SHALL be an output, 8 bits wide, carrying the serial byte; it SHALL be registered.
REQ-008 The port valid_out_32x8 SHALL be an output, 1 bit wide, and mark data_out_32x8 as carrying a valid byte; it SHALL be registered.
REQ-009 The port words_sent SHALL be an output, 8 bits wide, and count completed words; it SHALL be registered.

Function
REQ-010 The block SHALL be the transmit counterpart of the 8x32 demux: one 32-bit word in, four bytes out on consecutive clk_4f cycles, MSB byte first ([31:24], [23:16], [15:8], [7:0]).
REQ-011 The block SHALL have two states, IDLE and SEND, with a 2-bit byte index idx valid only in SEND.
REQ-012 ready_out_32x8 SHALL be combinational and equal to (state==IDLE) || (state==SEND && idx==3).
REQ-013 A word SHALL be accepted on a rising edge where valid_in_32x8 && ready_out_32x8; valid_in_32x8 with ready low SHALL be ignored, with no state change.
REQ-014 On the accept edge, the block SHALL load the word into the shift register, drive data_out_32x8 <= data_in_32x8[31:24] and valid_out_32x8 <= 1, and set state=SEND, idx=0; latency from accept edge to first byte SHALL be 0 edges (visible after that edge).
REQ-015 In SEND with idx<3, each edge SHALL output the next byte, increment idx, and hold valid_out_32x8=1.
REQ-016 In SEND with idx==3 and no accept, the next edge SHALL go to IDLE and clear valid_out_32x8; data_out_32x8 follows REQ-024/025.
REQ-017 In SEND with idx==3 and an accept, the next edge SHALL start the new word (REQ-014) with no bubble; back-to-back words SHALL give a continuous valid_out_32x8 stream.
REQ-018 words_sent SHALL increment by 1 on each edge leaving idx==3, with or without a new accept, and wrap 255 -> 0.
REQ-019 data_in_32x8 SHALL be sampled only on the accept edge; later changes SHALL NOT affect bytes in flight.
REQ-020 A word with all bytes zero SHALL be serialized normally, with valid_out_32x8=1 for 4 cycles.

Reset
REQ-021 While reset_L=0, the block SHALL hold state=IDLE, idx=0, shift register 0, data_out_32x8=8'h00, valid_out_32x8=0, words_sent=0; ready_out_32x8 SHALL then be 1 (combinational from IDLE), but no word SHALL be accepted while reset is held.
REQ-022 Reset asserted mid-word SHALL immediately discard the partial word; that word SHALL NOT count in words_sent.
REQ-023 On the first rising edge after reset_L goes 1, the block SHALL accept a word normally.

Configuration
REQ-024 With macro IDLE_CHAR_EN defined, data_out_32x8 SHALL drive 8'hBC on every non-reset cycle where valid_out_32x8=0.
REQ-025 Without IDLE_CHAR_EN, data_out_32x8 SHALL be 8'h00 whenever valid_out_32x8=0; valid_out_32x8 and handshake behaviour SHALL be identical in both builds.

Verification
REQ-026 Reset, then accept 32'hA1B2C3D4 in IDLE -> bytes A1,B2,C3,D4 on 4 consecutive cycles, valid=1, then valid=0 and words_sent=1.
REQ-027 Hold valid_in_32x8=1 with words 32'h01020304 then 32'h05060708 -> 8 continuous valid bytes 01..08, ready high only on idx==3 cycles, words_sent=2.
REQ-028 Change data_in_32x8 to 32'hFFFFFFFF while sending 32'h11223344 with ready low -> output stays 11,22,33,44 and the change is ignored.
REQ-029 Assert reset_L=0 after byte 2 of 32'hDEADBEEF -> outputs clear immediately, words_sent=0, and the next word serializes correctly.
REQ-030 Idle for 3 cycles -> data_out_32x8=8'hBC with IDLE_CHAR_EN and 8'h00 without, valid_out_32x8=0 in both.
REQ-031 Send 256 words -> words_sent wraps to 0.

Source files
------------

// File: rtl/mux_32x8.sv
// ---------------------------------------------------------------------------
// mux_32x8 -- 32-bit to 8-bit serializer (transmit side of the 8x32 demux).
//
// A 32-bit word is accepted with a valid/ready handshake and sent out as
// four bytes on consecutive clk_4f cycles, most significant byte first.
// A new word can be accepted on the cycle that shows the last byte of the
// current word, so back-to-back words form a gapless byte stream.
//
// Ports:
//   clk_4f          in   1   byte-rate clock, all state on rising edge
//   reset_L         in   1   asynchronous active-low reset
//   data_in_32x8    in   32  parallel word to serialize
//   valid_in_32x8   in   1   data_in_32x8 is valid
//   ready_out_32x8  out  1   a word offered now is taken on the next edge
//   data_out_32x8   out  8   serial byte (registered)
//   valid_out_32x8  out  1   data_out_32x8 carries a byte (registered)
//   words_sent      out  8   completed-word counter, wraps at 256
//
// Configuration macro:
//   IDLE_CHAR_EN    when defined, data_out_32x8 shows 8'hBC while no byte
//                   is being sent (outside reset); otherwise it shows 8'h00.
// ---------------------------------------------------------------------------
module mux_32x8 (
  input  logic        clk_4f,
  input  logic        reset_L,
  input  logic [31:0] data_in_32x8,
  input  logic        valid_in_32x8,
  output logic        ready_out_32x8,
  output logic [7:0]  data_out_32x8,
  output logic        valid_out_32x8,
  output logic [7:0]  words_sent
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

`ifdef IDLE_CHAR_EN
  localparam logic [7:0] IDLE_BYTE = 8'hBC;
`else
  localparam logic [7:0] IDLE_BYTE = 8'h00;
`endif

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic [7:0]  words_q, words_d;
  logic        lastByte;
  logic        accept;

  assign lastByte       = (state_q == SEND) && (idx_q == 2'd3);
  assign ready_out_32x8 = (state_q == IDLE) || lastByte;
  assign accept         = valid_in_32x8 && ready_out_32x8;

  // Next-state logic. The first byte goes straight from the input to the
  // output register, so the shift register only needs to hold the three
  // remaining bytes, left-aligned; each SEND step emits its top byte.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    words_d = words_q;

    // A word completes on every edge that leaves the last-byte cycle.
    if (lastByte) begin
      words_d = words_q + 8'd1;
    end

    if (accept) begin
      state_d = SEND;
      idx_d   = 2'd0;
      shift_d = {data_in_32x8[23:0], 8'h00};
      data_d  = data_in_32x8[31:24];
      valid_d = 1'b1;
    end else if ((state_q == SEND) && !lastByte) begin
      idx_d   = idx_q + 2'd1;
      shift_d = {shift_q[23:0], 8'h00};
      data_d  = shift_q[31:24];
      valid_d = 1'b1;
    end else begin
      state_d = IDLE;
      idx_d   = 2'd0;
      data_d  = IDLE_BYTE;
      valid_d = 1'b0;
    end
  end

  // State registers; reset discards any partially sent word.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      shift_q <= 32'h0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      words_q <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      words_q <= words_d;
    end
  end

  assign data_out_32x8  = data_q;
  assign valid_out_32x8 = valid_q;
  assign words_sent     = words_q;

endmodule

// File: tb/tb_mux_32x8.sv
// ---------------------------------------------------------------------------
// tb_mux_32x8 -- self-checking bench for mux_32x8.
// The reference model is a byte queue: an accepted word pushes its four
// bytes, every clock edge pops one byte to the output, and a word counts
// as sent when its last byte leaves the output.
// ---------------------------------------------------------------------------
module tb_mux_32x8;

  logic        clk_4f = 1'b0;
  logic        reset_L = 1'b0;
  logic [31:0] data_in_32x8 = 32'h0;
  logic        valid_in_32x8 = 1'b0;
  logic        ready_out_32x8;
  logic [7:0]  data_out_32x8;
  logic        valid_out_32x8;
  logic [7:0]  words_sent;

`ifdef IDLE_CHAR_EN
  localparam logic [7:0] IDLE_BYTE = 8'hBC;
`else
  localparam logic [7:0] IDLE_BYTE = 8'h00;
`endif

  mux_32x8 dut (
    .clk_4f         (clk_4f),
    .reset_L        (reset_L),
    .data_in_32x8   (data_in_32x8),
    .valid_in_32x8  (valid_in_32x8),
    .ready_out_32x8 (ready_out_32x8),
    .data_out_32x8  (data_out_32x8),
    .valid_out_32x8 (valid_out_32x8),
    .words_sent     (words_sent)
  );

  always #5 clk_4f = ~clk_4f;

  int total = 0;
  int bad   = 0;

  logic [7:0] byteQ[$];
  logic [7:0] expData;
  logic       expValid;
  logic [7:0] expWords;
  int         acceptedWords;

  function automatic logic expReady();
    return (byteQ.size() == 0);
  endfunction

  // Clear the model to its reset picture.
  task automatic modelReset();
    byteQ.delete();
    expData  = 8'h00;
    expValid = 1'b0;
    expWords = 8'h00;
  endtask

  // Drive reset low, then release it away from a clock edge.
  task automatic applyReset();
    @(negedge clk_4f);
    reset_L = 1'b0;
    modelReset();
    @(negedge clk_4f);
    reset_L = 1'b1;
  endtask

  // Advance one clock edge and update the model; outputs are then sampled
  // 1 time unit after the edge.
  task automatic tick();
    logic       acc;
    logic [31:0] w;
    acc = valid_in_32x8 && expReady();
    w   = data_in_32x8;
    @(posedge clk_4f);
    if (expValid && byteQ.size() == 0) expWords = expWords + 8'd1;
    if (acc) begin
      byteQ.push_back(w[31:24]);
      byteQ.push_back(w[23:16]);
      byteQ.push_back(w[15:8]);
      byteQ.push_back(w[7:0]);
      acceptedWords++;
    end
    if (byteQ.size() > 0) begin
      expData  = byteQ.pop_front();
      expValid = 1'b1;
    end else begin
      expData  = IDLE_BYTE;
      expValid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk_4f);
    reset_L       = 1'b0;
    valid_in_32x8 = 1'b1;
    data_in_32x8  = $urandom;
    modelReset();
    repeat (3) @(posedge clk_4f);
    #1;
    total++; if (data_out_32x8 !== 8'h00) begin bad++; $display("[TB] FAIL reset_data got=%h want=00", data_out_32x8); end
    total++; if (valid_out_32x8 !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", valid_out_32x8); end
    total++; if (words_sent !== 8'h00) begin bad++; $display("[TB] FAIL reset_words got=%h want=00", words_sent); end
    total++; if (ready_out_32x8 !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b want=1", ready_out_32x8); end
    valid_in_32x8 = 1'b0;
    @(negedge clk_4f);
    reset_L = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] seen[$];
    data_in_32x8  = 32'hA1B2C3D4;
    valid_in_32x8 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      total++; if (ready_out_32x8 !== expReady()) begin bad++; $display("[TB] FAIL basic_ready cyc=%0d got=%b want=%b", c, ready_out_32x8, expReady()); end
      tick();
      valid_in_32x8 = 1'b0;
      total++; if (valid_out_32x8 !== expValid) begin bad++; $display("[TB] FAIL basic_valid cyc=%0d got=%b want=%b", c, valid_out_32x8, expValid); end
      total++; if (data_out_32x8 !== expData) begin bad++; $display("[TB] FAIL basic_data cyc=%0d got=%h want=%h", c, data_out_32x8, expData); end
      total++; if (words_sent !== expWords) begin bad++; $display("[TB] FAIL basic_words cyc=%0d got=%h want=%h", c, words_sent, expWords); end
      if (valid_out_32x8) seen.push_back(data_out_32x8);
    end
    total++; if (seen.size() != 4 || {seen[0], seen[1], seen[2], seen[3]} !== 32'hA1B2C3D4) begin bad++; $display("[TB] FAIL basic_bytes got=%0d bytes want=a1b2c3d4", seen.size()); end
    total++; if (words_sent !== 8'd1) begin bad++; $display("[TB] FAIL basic_count got=%0d want=1", words_sent); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seen[$];
    int readyHigh;
    applyReset();
    acceptedWords = 0;
    readyHigh     = 0;
    data_in_32x8  = 32'h01020304;
    valid_in_32x8 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (acceptedWords == 1) data_in_32x8 = 32'h05060708;
      if (acceptedWords == 2) valid_in_32x8 = 1'b0;
      total++; if (ready_out_32x8 !== expReady()) begin bad++; $display("[TB] FAIL b2b_ready cyc=%0d got=%b want=%b", c, ready_out_32x8, expReady()); end
      if (ready_out_32x8 && valid_out_32x8) readyHigh++;
      tick();
      total++; if (data_out_32x8 !== expData || valid_out_32x8 !== expValid) begin bad++; $display("[TB] FAIL b2b_out cyc=%0d got=%h/%b want=%h/%b", c, data_out_32x8, valid_out_32x8, expData, expValid); end
      if (valid_out_32x8) seen.push_back(data_out_32x8);
      else if (seen.size() > 0 && seen.size() < 8) begin bad++; total++; $display("[TB] FAIL b2b_gap cyc=%0d got=%0d bytes want=8", c, seen.size()); end
    end
    total++; if (seen.size() != 8 || seen[0] !== 8'h01 || seen[4] !== 8'h05 || seen[7] !== 8'h08) begin bad++; $display("[TB] FAIL b2b_stream got=%0d bytes want=8 (01..08)", seen.size()); end
    total++; if (readyHigh != 2) begin bad++; $display("[TB] FAIL b2b_readycount got=%0d want=2", readyHigh); end
    total++; if (words_sent !== 8'd2) begin bad++; $display("[TB] FAIL b2b_words got=%0d want=2", words_sent); end
  endtask

  task automatic test_hold_input();
    logic [7:0] seen[$];
    applyReset();
    data_in_32x8  = 32'h11223344;
    valid_in_32x8 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      data_in_32x8  = 32'hFFFFFFFF;
      valid_in_32x8 = (c < 2);
      total++; if (data_out_32x8 !== expData || valid_out_32x8 !== expValid) begin bad++; $display("[TB] FAIL hold_out cyc=%0d got=%h/%b want=%h/%b", c, data_out_32x8, valid_out_32x8, expData, expValid); end
      if (valid_out_32x8) seen.push_back(data_out_32x8);
    end
    total++; if (seen.size() != 4 || {seen[0], seen[1], seen[2], seen[3]} !== 32'h11223344) begin bad++; $display("[TB] FAIL hold_bytes got=%0d bytes want=11223344", seen.size()); end
    total++; if (words_sent !== 8'd1) begin bad++; $display("[TB] FAIL hold_words got=%0d want=1", words_sent); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    applyReset();
    data_in_32x8  = 32'hDEADBEEF;
    valid_in_32x8 = 1'b1;
    tick();
    valid_in_32x8 = 1'b0;
    tick();
    total++; if (data_out_32x8 !== 8'hAD) begin bad++; $display("[TB] FAIL mid_byte2 got=%h want=ad", data_out_32x8); end
    #2;
    reset_L = 1'b0;
    modelReset();
    #1;
    total++; if (data_out_32x8 !== 8'h00 || valid_out_32x8 !== 1'b0) begin bad++; $display("[TB] FAIL mid_clear got=%h/%b want=00/0", data_out_32x8, valid_out_32x8); end
    @(negedge clk_4f);
    reset_L = 1'b1;
    w = $urandom;
    data_in_32x8  = w;
    valid_in_32x8 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      valid_in_32x8 = 1'b0;
      total++; if (data_out_32x8 !== expData || valid_out_32x8 !== expValid) begin bad++; $display("[TB] FAIL mid_next cyc=%0d got=%h/%b want=%h/%b", c, data_out_32x8, valid_out_32x8, expData, expValid); end
    end
    total++; if (words_sent !== 8'd1) begin bad++; $display("[TB] FAIL mid_words got=%0d want=1", words_sent); end
  endtask

  task automatic test_idle();
    valid_in_32x8 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (data_out_32x8 !== IDLE_BYTE || valid_out_32x8 !== 1'b0) begin bad++; $display("[TB] FAIL idle cyc=%0d got=%h/%b want=%h/0", c, data_out_32x8, valid_out_32x8, IDLE_BYTE); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      valid_in_32x8 = ($urandom_range(0, 3) != 0);
      data_in_32x8  = $urandom;
      total++; if (ready_out_32x8 !== expReady()) begin bad++; $display("[TB] FAIL rand_ready cyc=%0d got=%b want=%b", c, ready_out_32x8, expReady()); end
      tick();
      total++; if (data_out_32x8 !== expData || valid_out_32x8 !== expValid || words_sent !== expWords) begin bad++; $display("[TB] FAIL rand_out cyc=%0d got=%h/%b/%0d want=%h/%b/%0d", c, data_out_32x8, valid_out_32x8, words_sent, expData, expValid, expWords); end
    end
    valid_in_32x8 = 1'b0;
  endtask

  task automatic test_wrap();
    applyReset();
    acceptedWords = 0;
    valid_in_32x8 = 1'b1;
    for (int c = 0; c < 256 * 4 + 2; c++) begin
      if (acceptedWords >= 256) valid_in_32x8 = 1'b0;
      data_in_32x8 = $urandom;
      tick();
      if (words_sent !== expWords) begin total++; bad++; $display("[TB] FAIL wrap_track cyc=%0d got=%0d want=%0d", c, words_sent, expWords); end
    end
    total++; if (words_sent !== 8'd0) begin bad++; $display("[TB] FAIL wrap_final got=%0d want=0", words_sent); end
    total++; if (acceptedWords != 256) begin bad++; $display("[TB] FAIL wrap_accepted got=%0d want=256", acceptedWords); end
  endtask

  initial begin
    modelReset();
    acceptedWords = 0;
    test_reset();
    test_basic();
    test_idle();
    test_back_to_back();
    test_hold_input();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
